// File: rtl/aq_f_spsram_lp_wrap_pkg.sv
// Shared types and defaults for the low-power single-port SRAM wrapper.
// The state encoding is visible on pwr_state, so it is fixed here rather than left to synthesis.
package aq_f_spsram_lp_wrap_pkg;

  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'b00,
    PWR_SLEEP  = 2'b01,
    PWR_DSLEEP = 2'b10,
    PWR_WAKE   = 2'b11
  } pwr_state_e;

  localparam int DEF_SLP_IDLE_CYC = 16;
  localparam int DEF_SD_IDLE_CYC  = 256;
  localparam int DEF_SLP_WAKE_CYC = 1;
  localparam int DEF_SD_WAKE_CYC  = 4;

  // Width that holds the larger of two thresholds without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/aq_f_spsram_array.sv
// Behavioural single-port SRAM macro: active-low CEB/WEB/BWEB, 1-cycle read, Q held when idle.
// Q is forced to zero while in light or deep sleep; replaced by the foundry macro wrapper in ASIC builds.
module aq_f_spsram_array #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  ceb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [DATA_WIDTH-1:0] bweb,
  input  logic                  slp,
  input  logic                  sd,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic                  powered;

  assign powered = !slp && !sd;

  always_ff @(posedge clk) begin
    if (!ceb && !web && powered) begin
      mem[a] <= (mem[a] & bweb) | (d & ~bweb);
    end
  end

  always_ff @(posedge clk) begin
    if (!powered) begin
      q <= '0;
    end else if (!ceb && web) begin
      q <= mem[a];
    end
  end

endmodule

// File: rtl/aq_f_spsram_lp_wrap.sv
// SRAM wrapper: valid/ready request port, read data 1+OUT_REG cycles after accept, no response backpressure.
// Idle-driven sleep/deep-sleep sequencing; requests are held off (req_rdy=0) until the timed wake completes.
module aq_f_spsram_lp_wrap
  import aq_f_spsram_lp_wrap_pkg::*;
#(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 8,
  parameter int OUT_REG      = 1,
  parameter int SLP_IDLE_CYC = DEF_SLP_IDLE_CYC,
  parameter int SD_IDLE_CYC  = DEF_SD_IDLE_CYC,
  parameter int SLP_WAKE_CYC = DEF_SLP_WAKE_CYC,
  parameter int SD_WAKE_CYC  = DEF_SD_WAKE_CYC
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  lp_en,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bwen,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            pwr_state
);

  localparam int ICW = cnt_width(SLP_IDLE_CYC, SD_IDLE_CYC);
  localparam int WCW = cnt_width(SLP_WAKE_CYC, SD_WAKE_CYC);

  pwr_state_e            state_q, state_d;
  logic [ICW-1:0]        idle_q, idle_d;
  logic [WCW-1:0]        wake_q, wake_d;
  logic                  accept;
  logic                  rd_p1_q;
  logic                  rd_inflight;
  logic [DATA_WIDTH-1:0] mem_q;

  assign req_rdy   = (state_q == PWR_ACTIVE);
  assign accept    = req_vld && req_rdy;
  assign pwr_state = state_q;

  aq_f_spsram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (forever_cpuclk),
    .ceb  (!accept),
    .web  (!req_wr),
    .a    (req_addr),
    .d    (req_wdata),
    .bweb (~req_bwen),
    .slp  (state_q == PWR_SLEEP),
    .sd   (state_q == PWR_DSLEEP),
    .q    (mem_q)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= PWR_ACTIVE;
      idle_q  <= '0;
      wake_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    case (state_q)
      PWR_ACTIVE: begin
        // An accept on the threshold cycle takes priority over sleep entry.
        if (accept || rd_inflight || !lp_en) begin
          idle_d = '0;
        end else if (idle_q == ICW'(SLP_IDLE_CYC - 1)) begin
          state_d = PWR_SLEEP;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      PWR_SLEEP: begin
        if (req_vld || !lp_en) begin
          state_d = PWR_WAKE;
          wake_d  = WCW'(SLP_WAKE_CYC);
          idle_d  = '0;
        end else if (idle_q == ICW'(SD_IDLE_CYC - 1)) begin
          state_d = PWR_DSLEEP;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      PWR_DSLEEP: begin
        if (req_vld || !lp_en) begin
          state_d = PWR_WAKE;
          wake_d  = WCW'(SD_WAKE_CYC);
        end
      end
      PWR_WAKE: begin
        if (wake_q <= WCW'(1)) begin
          state_d = PWR_ACTIVE;
          wake_d  = '0;
        end else begin
          wake_d = wake_q - 1'b1;
        end
      end
      default: state_d = PWR_ACTIVE;
    endcase
  end

  // rd_p1_q marks the cycle the macro Q carries the read word.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_p1_q <= 1'b0;
    end else begin
      rd_p1_q <= accept && !req_wr;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  rd_p2_q;
      logic [DATA_WIDTH-1:0] rdata_q;

      always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
          rd_p2_q <= 1'b0;
          rdata_q <= '0;
        end else begin
          rd_p2_q <= rd_p1_q;
          if (rd_p1_q) begin
            rdata_q <= mem_q;
          end
        end
      end

      assign rsp_vld     = rd_p2_q;
      assign rsp_rdata   = rdata_q;
      assign rd_inflight = rd_p1_q || rd_p2_q;
    end else begin : g_noreg
      logic [DATA_WIDTH-1:0] hold_q;

      // Q drops to zero in sleep, so the last response is kept locally.
      always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
          hold_q <= '0;
        end else if (rd_p1_q) begin
          hold_q <= mem_q;
        end
      end

      assign rsp_vld     = rd_p1_q;
      assign rsp_rdata   = rd_p1_q ? mem_q : hold_q;
      assign rd_inflight = rd_p1_q;
    end
  endgenerate

endmodule

// File: tb/tb_aq_f_spsram_lp_wrap.sv
// Scoreboard bench for aq_f_spsram_lp_wrap: reads push expected data and arrival cycle; a monitor pops on rsp_vld.
module tb_aq_f_spsram_lp_wrap;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lp_en = 1'b0;
  logic       req_vld = 1'b0;
  logic       req_wr = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [7:0] req_bwen = '0;
  logic       req_rdy;
  logic       rsp_vld;
  logic [7:0] rsp_rdata;
  logic [1:0] pwr_state;

  aq_f_spsram_lp_wrap dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .lp_en          (lp_en),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_bwen       (req_bwen),
    .rsp_vld        (rsp_vld),
    .rsp_rdata      (rsp_rdata),
    .pwr_state      (pwr_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request, wait (bounded) for acceptance, count WAKE cycles seen while held off.
  task automatic do_req(input bit wr, input logic [6:0] a, input logic [7:0] wd,
                        input logic [7:0] bw, input logic [7:0] ed, output int wake);
    int   n;
    exp_t e;
    wake = 0;
    n = 0;
    req_vld = 1'b1;
    req_wr = wr;
    req_addr = a;
    req_wdata = wd;
    req_bwen = bw;
    @(negedge clk);
    while (!req_rdy && n < 50) begin
      if (pwr_state == 2'b11) wake++;
      n++;
      @(negedge clk);
    end
    if (!req_rdy) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: req_rdy=%0d after %0d cycles, expected 1", req_rdy, n);
    end else if (!wr) begin
      e.data = ed;
      e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
  endtask

  task automatic enter_sleep();
    lp_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    lp_en = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("pre_sleep_state", pwr_state, 2'b00);
    @(posedge clk);
    @(negedge clk);
    chk("sleep_state", pwr_state, 2'b01);
    chk("sleep_rdy", req_rdy, 1'b0);
  endtask

  task automatic monitor();
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (rst_n && rsp_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rsp_vld=1 data=0x%0h, expected no response", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_rdata, e.data);
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic stimulus();
    int w;
    int n;
    bit slept;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_vld", rsp_vld, 1'b0);
    chk("rst_req_rdy", req_rdy, 1'b1);
    chk("rst_pwr_state", pwr_state, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full write and read back
    do_req(1'b1, 7'h05, 8'hA5, 8'hFF, 8'h00, w);
    do_req(1'b0, 7'h05, 8'h00, 8'h00, 8'hA5, w);

    // Masked write, then back-to-back reads
    do_req(1'b1, 7'h05, 8'h00, 8'h0F, 8'h00, w);
    do_req(1'b1, 7'h06, 8'h3C, 8'hFF, 8'h00, w);
    do_req(1'b0, 7'h05, 8'h00, 8'h00, 8'hA0, w);
    do_req(1'b0, 7'h06, 8'h00, 8'h00, 8'h3C, w);
    do_req(1'b1, 7'h06, 8'hFF, 8'hFF, 8'h00, w);
    repeat (4) @(posedge clk);
    #1;
    chk("rdata_hold", rsp_rdata, 8'h3C);

    // Light sleep, then deep sleep after 256 further idle cycles
    enter_sleep();
    repeat (255) @(posedge clk);
    @(negedge clk);
    chk("pre_dsleep_state", pwr_state, 2'b01);
    @(posedge clk);
    @(negedge clk);
    chk("dsleep_state", pwr_state, 2'b10);
    chk("dsleep_rdy", req_rdy, 1'b0);

    // Wake from deep sleep, rewrite, then wake from light sleep with retained data
    do_req(1'b1, 7'h07, 8'h5A, 8'hFF, 8'h00, w);
    chk("wake_from_dsleep", w, 4);
    do_req(1'b0, 7'h07, 8'h00, 8'h00, 8'h5A, w);
    enter_sleep();
    do_req(1'b0, 7'h05, 8'h00, 8'h00, 8'hA0, w);
    chk("wake_from_sleep", w, 1);

    // Request on the threshold cycle wins over sleep entry
    lp_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    lp_en = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    do_req(1'b0, 7'h06, 8'h00, 8'h00, 8'hFF, w);
    chk("threshold_wake_cycles", w, 0);
    @(negedge clk);
    chk("threshold_stays_active", pwr_state, 2'b00);
    lp_en = 1'b0;
    slept = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (pwr_state != 2'b00) slept = 1'b1;
    end
    chk("no_sleep_lp_off", slept, 1'b0);

    // Reset with a read in flight
    @(posedge clk);
    #1;
    req_vld = 1'b1;
    req_wr = 1'b0;
    req_addr = 7'h05;
    @(negedge clk);
    chk("inflight_rdy", req_rdy, 1'b1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_vld", rsp_vld, 1'b0);
    chk("midrst_pwr_state", pwr_state, 2'b00);
    chk("midrst_req_rdy", req_rdy, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_rsp_vld_late", rsp_vld, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b1, 7'h09, 8'h77, 8'hFF, 8'h00, w);
    do_req(1'b0, 7'h09, 8'h00, 8'h00, 8'h77, w);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
